// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: round-robin sequencer gating NUM_CLKS clock domains with checker expectations
module clock_gate_ctrl #(
  parameter int NUM_CLKS    = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int WAKE_CYC    = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CLKS-1:0] gate_req,
  input  logic [NUM_CLKS-1:0] dom_idle,
  input  logic                err_clr,
  output logic [NUM_CLKS-1:0] clk_en,
  output logic [NUM_CLKS-1:0] chk_gate,
  output logic [NUM_CLKS-1:0] chk_skip_dly,
  output logic [NUM_CLKS-1:0] gated,
  output logic                busy,
  output logic [NUM_CLKS-1:0] timeout_err
);
  localparam int IW = NUM_CLKS > 1 ? $clog2(NUM_CLKS) : 1;
  typedef enum logic [2:0] {S_ON, S_DRAIN, S_GATE, S_OFF, S_WAKE} state_t;
  state_t st [NUM_CLKS];
  state_t st_n [NUM_CLKS];
  logic [IW-1:0] hold, hold_n, ptr, ptr_n, win;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_CLKS-1:0] lock, lock_n, err_n, req;
  logic busy_n, found;
  int idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLKS; i++) st[i] <= S_ON;
      hold <= '0;
      ptr <= '0;
      cnt <= '0;
      busy <= 1'b0;
      lock <= '0;
      timeout_err <= '0;
    end else begin
      st <= st_n;
      hold <= hold_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      busy <= busy_n;
      lock <= lock_n;
      timeout_err <= err_n;
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      clk_en[i] = st[i] inside {S_ON, S_DRAIN, S_WAKE};
      chk_gate[i] = st[i] == S_OFF;
      chk_skip_dly[i] = st[i] inside {S_GATE, S_OFF, S_WAKE};
      gated[i] = st[i] inside {S_OFF, S_WAKE};
      req[i] = (st[i] == S_ON && gate_req[i] && !lock[i]) || (st[i] == S_OFF && !gate_req[i]);
    end
  end
  // first requester at or after the pointer, wrapping modulo NUM_CLKS
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_CLKS; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= NUM_CLKS ? idx - NUM_CLKS : idx;
      if (!found && req[idx]) begin
        found = 1'b1;
        win = IW'(idx);
      end
    end
  end
  always_comb begin
    st_n = st;
    hold_n = hold;
    ptr_n = ptr;
    busy_n = busy;
    cnt_n = &cnt ? cnt : cnt + 1'b1;
    lock_n = lock & gate_req;
    err_n = err_clr ? '0 : timeout_err;
    if (busy) begin
      case (st[hold])
        S_DRAIN: begin
          if (dom_idle[hold]) begin
            st_n[hold] = S_GATE;
            cnt_n = '0;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            st_n[hold] = S_ON;
            err_n[hold] = 1'b1;
            lock_n[hold] = 1'b1;
            busy_n = 1'b0;
          end
        end
        S_GATE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          st_n[hold] = S_OFF;
          busy_n = 1'b0;
        end
        S_WAKE: if (cnt == CNT_W'(WAKE_CYC - 1)) begin
          st_n[hold] = S_ON;
          busy_n = 1'b0;
        end
        default: busy_n = 1'b0;
      endcase
    end else if (found) begin
      st_n[win] = st[win] == S_ON ? S_DRAIN : S_WAKE;
      hold_n = win;
      busy_n = 1'b1;
      cnt_n = '0;
      ptr_n = win == IW'(NUM_CLKS - 1) ? '0 : win + 1'b1;
    end
  end
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: directed and random stimulus against a countdown-timer reference model
module tb_clock_gate_ctrl;
  localparam int N = 2;
  localparam int SETTLE = 4;
  localparam int WAKE = 4;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] gate_req = '0;
  logic [N-1:0] dom_idle = '0;
  logic err_clr = 1'b0;
  logic [N-1:0] clk_en, chk_gate, chk_skip_dly, gated, timeout_err;
  logic busy;
  int checks = 0;
  int errors = 0;
  int ph [N];
  bit off [N];
  bit lk [N];
  bit er [N];
  int left;
  int owner;
  int ptr;
  clock_gate_ctrl #(.NUM_CLKS(N), .SETTLE_CYC(SETTLE), .WAKE_CYC(WAKE), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .gate_req(gate_req), .dom_idle(dom_idle), .err_clr(err_clr),
    .clk_en(clk_en), .chk_gate(chk_gate), .chk_skip_dly(chk_skip_dly), .gated(gated),
    .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  // ph: 0 steady (ON or OFF per off[]), 1 draining, 2 settling, 3 waking
  task automatic model_step();
    int o;
    int i;
    if (rst) begin
      for (int d = 0; d < N; d++) begin ph[d] = 0; off[d] = 0; lk[d] = 0; er[d] = 0; end
      owner = -1; ptr = 0; left = 0;
      return;
    end
    for (int d = 0; d < N; d++) begin
      lk[d] = lk[d] && gate_req[d];
      if (err_clr) er[d] = 0;
    end
    if (owner >= 0) begin
      o = owner;
      if (ph[o] == 1) begin
        if (dom_idle[o]) begin ph[o] = 2; left = SETTLE; end
        else begin
          left--;
          if (left == 0) begin ph[o] = 0; er[o] = 1; lk[o] = 1; owner = -1; end
        end
      end else begin
        left--;
        if (left == 0) begin off[o] = ph[o] == 2; ph[o] = 0; owner = -1; end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (owner < 0 && (off[i] ? !gate_req[i] : (gate_req[i] && !lk[i]))) begin
          owner = i;
          ph[i] = off[i] ? 3 : 1;
          left = off[i] ? WAKE : TMO;
          ptr = (i + 1) % N;
        end
      end
    end
  endtask
  task automatic compare();
    logic [N-1:0] e_en, e_gate, e_skip, e_gated, e_err;
    int active;
    active = 0;
    for (int d = 0; d < N; d++) begin
      e_en[d] = ph[d] == 0 ? !off[d] : ph[d] != 2;
      e_gate[d] = off[d] && ph[d] == 0;
      e_skip[d] = ph[d] >= 2 || (off[d] && ph[d] == 0);
      e_gated[d] = off[d];
      e_err[d] = er[d];
      active += ph[d] != 0;
    end
    check("clk_en", 32'(clk_en), 32'(e_en));
    check("chk_gate", 32'(chk_gate), 32'(e_gate));
    check("chk_skip_dly", 32'(chk_skip_dly), 32'(e_skip));
    check("gated", 32'(gated), 32'(e_gated));
    check("busy", 32'(busy), 32'(owner >= 0));
    check("timeout_err", 32'(timeout_err), 32'(e_err));
    check("gate_while_running", 32'(chk_gate & clk_en), 32'd0);
    check("model_single_active", 32'(active <= 1), 32'd1);
  endtask
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask
  initial begin
    int thr;
    dom_idle = '1;
    run(2);
    rst = 1'b0;
    gate_req = 2'b01;
    run(10);
    gate_req = 2'b00;
    run(8);
    gate_req = 2'b10; dom_idle = 2'b00;
    run(14);
    gate_req = 2'b00;
    run(1);
    gate_req = 2'b10; dom_idle = 2'b11;
    run(10);
    err_clr = 1'b1;
    run(1);
    err_clr = 1'b0;
    gate_req = 2'b00;
    run(10);
    gate_req = 2'b11;
    run(16);
    gate_req = 2'b00;
    run(16);
    gate_req = 2'b01;
    run(3);
    gate_req = 2'b00;
    run(14);
    gate_req = 2'b01;
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0; gate_req = 2'b00;
    run(3);
    thr = 9;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) thr = $urandom_range(0, 1) ? 9 : 1;
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 5) == 0) gate_req[d] = ~gate_req[d];
        dom_idle[d] = $urandom_range(0, 9) < thr;
      end
      err_clr = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 499) == 0;
      run(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Synthesizable per-domain clock-gate sequencer for NUM_CLKS gated clock domains. Examples are a functional clock and a core clock.
- Drives each domain's clock enable (the AND-gate enable) from a level gate request.
- Waits for the domain to go idle before gating; only one domain may transition at a time, granted round-robin.
- Generates expectation outputs (chk_gate, chk_skip_dly) in lockstep with the enables, so the clock-gate checker can be wired directly to the controller.

Parameters:
- NUM_CLKS, 2, number of controlled clock domains.
- SETTLE_CYC, 4, cycles between dropping clk_en and asserting chk_gate/gated (min 1).
- WAKE_CYC, 4, cycles between raising clk_en and clearing chk_skip_dly/gated (min 1).
- TIMEOUT_CYC, 64, maximum DRAIN cycles waiting for dom_idle before aborting (min 1).
- CNT_W, 8, shared counter width; must hold max(SETTLE_CYC, WAKE_CYC, TIMEOUT_CYC).

Ports:
- clk  in  1  always-on controller clock.
- rst  in  1  synchronous, active-high reset.
- gate_req  in  NUM_CLKS  level per domain: 1 = domain should be gated, 0 = running.
- dom_idle  in  NUM_CLKS  domain reports no traffic; safe to gate.
- err_clr  in  1  single-cycle pulse; clears all timeout_err bits.
- clk_en  out  NUM_CLKS  clock enable to each gate.
- chk_gate  out  NUM_CLKS  checker expectation: clock is stopped.
- chk_skip_dly  out  NUM_CLKS  checker relaxation window around transitions.
- gated  out  NUM_CLKS  status: domain fully gated.
- busy  out  1  a transition token is held.
- timeout_err  out  NUM_CLKS  sticky drain-timeout flag.

Behaviour:
- **Reset** (sync, active-high): all domains go to ON.
  - Reset values: clk_en all 1; chk_gate, chk_skip_dly, gated, timeout_err all 0; busy 0; counter 0; round-robin pointer 0.
  - Reset mid-transition aborts the transition immediately to these values.
- **Per-domain FSM** states: ON, DRAIN, GATE, OFF, WAKE.
  - ON: clk_en=1, chk_skip_dly=0. Requests the token when gate_req=1 and the domain is not locked out.
  - OFF: clk_en=0, chk_gate=1, chk_skip_dly=1, gated=1. Requests the token when gate_req=0.
- **Arbiter**
  - Single token; grant decided on the edge requests are sampled.
  - Winner is the first requester at or after the pointer, modulo NUM_CLKS. The pointer moves to winner+1.
  - A grant is given only when the token is free. The grant edge moves the winner to DRAIN (from ON) or WAKE (from OFF), resets the counter, and sets busy=1.
  - The token is released on the edge the holder reaches ON or OFF. A new grant can occur on the following edge, so there is 1 idle cycle with busy=0 between transitions.
- **DRAIN**
  - Each edge with dom_idle=1: go to GATE, clk_en=0, chk_skip_dly=1, counter reset.
  - Otherwise counter increments. On the edge the count reaches TIMEOUT_CYC: return to ON, set timeout_err[i], release the token, and lock out domain i until gate_req[i] is seen 0.
- **GATE**: after SETTLE_CYC edges in GATE, go to OFF and set chk_gate=1, gated=1 on that edge.
- **WAKE**
  - The entry edge sets clk_en=1 and chk_gate=0 together. The checker must never see chk_gate=1 while the clock runs.
  - After WAKE_CYC edges in WAKE: go to ON, chk_skip_dly=0, gated=0.
- **gate_req changes** during DRAIN/GATE/WAKE are ignored. The level is re-evaluated once the domain is in ON or OFF.
  - A gate_req pulse that starts and ends outside ON/OFF is lost. This is intended.
- **Ordering rule**: chk_gate rises strictly after clk_en falls (SETTLE_CYC later), and falls no later than clk_en rises (same edge).
- **timeout_err**
  - err_clr clears all bits.
  - If a new timeout occurs on the same edge as err_clr, the set wins for that bit.
- **Counter**: one shared CNT_W counter owned by the token holder. It saturates and never wraps.

Test Plan:
1. **Gate, then ungate one domain.** Config: NUM_CLKS=2, SETTLE=4, WAKE=4. Stimulus: gate_req[0] rises before edge 1, dom_idle[0]=1.
   - Edge 1: DRAIN, busy=1. Edge 2: clk_en[0]=0, chk_skip_dly[0]=1. Edge 6: chk_gate[0]=1, gated[0]=1, busy=0.
   - Then drop gate_req[0]: 1 edge later, clk_en[0]=1 and chk_gate[0]=0 on the same edge; 4 edges later, chk_skip_dly[0]=0 and gated[0]=0.
2. **Drain timeout.** Config: TIMEOUT=8. Stimulus: gate_req[1]=1 with dom_idle[1]=0.
   - After 8 DRAIN edges: timeout_err[1]=1, clk_en[1] stays 1, domain returns to ON.
   - Holding gate_req[1]=1 does not retrigger. Toggling gate_req[1] 0 then 1 with dom_idle[1]=1 gates normally.
   - An err_clr pulse clears timeout_err[1].
3. **Simultaneous requests.** Stimulus: gate_req=2'b11 on the same edge, pointer 0.
   - Domain 0 transitions first. Domain 1 enters DRAIN only after domain 0 reaches OFF and 1 idle cycle has passed.
   - The next contention goes to domain 1 first.
4. **Request changes mid-transition.** Stimulus: drop gate_req[0] while domain 0 is in GATE.
   - Domain 0 still completes to OFF, then immediately requests the token and wakes.
   - clk_en[0] never glitches: 0 for at least SETTLE_CYC+1 cycles.
5. **Reset mid-GATE.** Stimulus: assert rst with domain 0 in GATE.
   - Next edge: clk_en=2'b11, chk_gate=0, chk_skip_dly=0, busy=0, timeout_err=0.
6. **Ordering property.** Over all runs, assert: chk_gate[i]=1 implies clk_en[i]=0, and at most one domain is in DRAIN/GATE/WAKE at any time.
